// File: rtl/fp_operand_loader.sv
// Assembles a 17-byte serial frame (opcode, operand A, operand B) into one FP operation
// with registered operand classification, plus error pulses for bad opcodes and stalled frames.
module fp_operand_loader #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_op,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [2:0]  out_cls_a,
  output logic [2:0]  out_cls_b,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t        state, state_next;
  logic [2:0]    cnt;
  logic [TW-1:0] idle_cnt;
  logic [63:0]   acc_a;
  logic [55:0]   acc_b;
  logic [1:0]    op_q;
  logic [1:0]    op_dec;
  logic          op_ok;
  logic          accept;
  logic          loading;
  logic          last_byte;
  logic          timeout;

  // Sign bit is irrelevant to the class, so only exponent and fraction are passed in.
  function automatic logic [2:0] classify(input logic [62:0] m);
    logic all_ones;
    logic all_zero;
    logic frac_nz;
    all_ones = &m[62:52];
    all_zero = ~|m[62:52];
    frac_nz  = |m[51:0];
    return {all_ones & frac_nz, all_ones & ~frac_nz, all_zero & ~frac_nz};
  endfunction

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign loading   = (state == LOAD_A) || (state == LOAD_B);
  assign last_byte = (cnt == 3'd7);
  assign timeout   = loading && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    op_ok  = 1'b1;
    op_dec = 2'd0;
    case (in_data)
      8'h2B:   op_dec = 2'd0;
      8'h2D:   op_dec = 2'd1;
      8'h2A:   op_dec = 2'd2;
      8'h2F:   op_dec = 2'd3;
      default: op_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op_ok) state_next = LOAD_A;
      LOAD_A:  if (accept && last_byte) state_next = LOAD_B;
               else if (timeout)        state_next = IDLE;
      LOAD_B:  if (accept && last_byte) state_next = HOLD;
               else if (timeout)        state_next = IDLE;
      HOLD:    if (out_ready)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers load only on the final byte, so partial frames never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      idle_cnt  <= '0;
      acc_a     <= 64'd0;
      acc_b     <= 56'd0;
      op_q      <= 2'd0;
      out_op    <= 2'd0;
      out_a     <= 64'd0;
      out_b     <= 64'd0;
      out_cls_a <= 3'd0;
      out_cls_b <= 3'd0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err      <= 1'b0;
      err_code <= 2'd0;
      case (state)
        IDLE: begin
          cnt      <= 3'd0;
          idle_cnt <= '0;
          if (accept) begin
            if (op_ok) begin
              op_q <= op_dec;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (accept) begin
            cnt      <= cnt + 3'd1;
            idle_cnt <= '0;
            if (state == LOAD_A) begin
              acc_a <= {acc_a[55:0], in_data};
            end else begin
              acc_b <= {acc_b[47:0], in_data};
              if (last_byte) begin
                out_op    <= op_q;
                out_a     <= acc_a;
                out_b     <= {acc_b, in_data};
                out_cls_a <= classify(acc_a[62:0]);
                out_cls_b <= classify({acc_b[54:0], in_data});
              end
            end
          end else if (timeout) begin
            cnt      <= 3'd0;
            idle_cnt <= '0;
            err      <= 1'b1;
            err_code <= 2'd2;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          cnt      <= 3'd0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scoreboard bench for fp_operand_loader: expected operations are queued as frames are sent
// and popped when the loader presents an assembled operation.
module tb_fp_operand_loader;

  localparam int TMO = 20;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  ca;
    logic [2:0]  cb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_op;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  out_cls_a;
  logic [2:0]  out_cls_b;
  logic        err;
  logic [1:0]  err_code;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int n_err1 = 0;
  int n_err2 = 0;
  int n_err_bad = 0;
  int n_valid = 0;
  logic prev_valid = 1'b0;

  fp_operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_cls_a(out_cls_a), .out_cls_b(out_cls_b), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Counts error pulses by code and the number of distinct out_valid episodes.
  always @(negedge clk) begin
    if (err) begin
      if (err_code == 2'd1)      n_err1++;
      else if (err_code == 2'd2) n_err2++;
      else                       n_err_bad++;
    end
    if (out_valid && !prev_valid) n_valid++;
    prev_valid = out_valid;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2:0] cls_model(input logic [63:0] v);
    logic [63:0] m;
    m = v & 64'h7FFF_FFFF_FFFF_FFFF;
    return {m > 64'h7FF0_0000_0000_0000, m == 64'h7FF0_0000_0000_0000, m == 64'd0};
  endfunction

  function automatic exp_t make_exp(input logic [7:0] opc, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    case (opc)
      8'h2B:   e.op = 2'd0;
      8'h2D:   e.op = 2'd1;
      8'h2A:   e.op = 2'd2;
      default: e.op = 2'd3;
    endcase
    e.a  = a;
    e.b  = b;
    e.ca = cls_model(a);
    e.cb = cls_model(b);
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [63:0] a, input logic [63:0] b);
    sb.push_back(make_exp(opc, a, b));
    send_byte(opc);
    for (int i = 0; i < 8; i++) send_byte(a[63-8*i -: 8]);
    for (int i = 0; i < 8; i++) send_byte(b[63-8*i -: 8]);
  endtask

  task automatic get_out(output exp_t obs, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    ok  = out_valid;
    obs = {out_op, out_a, out_b, out_cls_a, out_cls_b};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready, err, err_code} !== 5'b01000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got valid/ready/err/code=%b, want 01000",
               {out_valid, in_ready, err, err_code});
    end
    vectors++;
    if ({out_op, out_a, out_b, out_cls_a, out_cls_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got op=%0d a=%h b=%h ca=%b cb=%b, want all zero",
               out_op, out_a, out_b, out_cls_a, out_cls_b);
    end
  endtask

  task automatic test_basic();
    exp_t obs, exp;
    bit ok;
    out_ready = 1'b1;
    send_frame(8'h2A, 64'h4000000000000000, 64'h4008000000000000);
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got valid/ready=%b, want 10", {out_valid, in_ready});
    end
    get_out(obs, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || obs !== exp || obs.op !== 2'd2 || obs.ca !== 3'b000 || obs.cb !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got op=%0d a=%h b=%h ca=%b cb=%b, want op=2 a=%h b=%h ca=000 cb=000",
               obs.op, obs.a, obs.b, obs.ca, obs.cb, exp.a, exp.b);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL basic_release: got valid/ready=%b, want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_bad_opcode();
    exp_t obs, exp;
    bit ok;
    int e1;
    e1 = n_err1;
    out_ready = 1'b1;
    send_byte(8'h41);
    vectors++;
    if ({err, err_code, in_ready} !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL bad_op_pulse: got err/code/ready=%b, want 1011", {err, err_code, in_ready});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({err, err_code} !== 3'b000 || n_err1 !== e1 + 1) begin
      miscompares++;
      $display("[TB] FAIL bad_op_single: got err/code=%b pulses=%0d, want 000 pulses=1",
               {err, err_code}, n_err1 - e1);
    end
    send_frame(8'h2D, 64'hC01E_0000_0000_0000, 64'h3FF0_0000_0000_0001);
    get_out(obs, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL bad_op_recover: got op=%0d a=%h b=%h ca=%b cb=%b, want op=%0d a=%h b=%h ca=%b cb=%b",
               obs.op, obs.a, obs.b, obs.ca, obs.cb, exp.op, exp.a, exp.b, exp.ca, exp.cb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    exp_t exp;
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    out_ready = 1'b0;
    send_frame(8'h2F, a, b);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready} !== 2'b10 || {out_op, out_a, out_b, out_cls_a, out_cls_b} !== exp) begin
        miscompares++;
        $display("[TB] FAIL hold_stable: cycle %0d valid/ready=%b op=%0d a=%h b=%h, want 10 op=%0d a=%h b=%h",
                 i, {out_valid, in_ready}, out_op, out_a, out_b, exp.op, exp.a, exp.b);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01 || {out_op, out_a, out_b, out_cls_a, out_cls_b} !== exp) begin
      miscompares++;
      $display("[TB] FAIL hold_release: valid/ready=%b op=%0d a=%h b=%h, want 01 op=%0d a=%h b=%h",
               {out_valid, in_ready}, out_op, out_a, out_b, exp.op, exp.a, exp.b);
    end
  endtask

  task automatic test_timeout();
    exp_t obs, exp;
    bit ok;
    int e2, v;
    logic [63:0] a, b;
    out_ready = 1'b1;
    e2 = n_err2;
    v  = n_valid;
    send_byte(8'h2A);
    for (int i = 0; i < 3; i++) send_byte(8'h11 + 8'(i));
    repeat (TMO - 1) @(posedge clk);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: err=%b one cycle before limit, want 0", err);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({err, err_code} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL timeout_pulse: got err/code=%b, want 110", {err, err_code});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (n_valid !== v || n_err2 !== e2 + 1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_abort: valids=%0d timeouts=%0d ready=%b, want 0 1 1",
               n_valid - v, n_err2 - e2, in_ready);
    end
    a = 64'h400921FB54442D18;
    b = 64'hBFE0000000000000;
    e2 = n_err2;
    sb.push_back(make_exp(8'h2A, a, b));
    send_byte(8'h2A);
    for (int i = 0; i < 3; i++) send_byte(a[63-8*i -: 8]);
    repeat (TMO - 1) @(posedge clk);
    #1;
    for (int i = 3; i < 8; i++) send_byte(a[63-8*i -: 8]);
    for (int i = 0; i < 8; i++) send_byte(b[63-8*i -: 8]);
    get_out(obs, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || obs !== exp || n_err2 !== e2) begin
      miscompares++;
      $display("[TB] FAIL gap_no_abort: ok=%b timeouts=%0d op=%0d a=%h b=%h, want ok=1 timeouts=0 op=%0d a=%h b=%h",
               ok, n_err2 - e2, obs.op, obs.a, obs.b, exp.op, exp.a, exp.b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_classify();
    exp_t obs, exp;
    bit ok;
    logic [63:0] va[3] = '{64'h0000000000000000, 64'h7FF8000000000001, 64'h0000000000000001};
    logic [63:0] vb[3] = '{64'h7FF0000000000000, 64'h8000000000000000, 64'hFFF0000000000000};
    logic [5:0]  want[3] = '{6'b001_010, 6'b100_001, 6'b000_010};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h2B, va[i], vb[i]);
      get_out(obs, ok);
      exp = sb.pop_front();
      vectors++;
      if (!ok || obs !== exp || {obs.ca, obs.cb} !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL classify_%0d: got a=%h b=%h ca=%b cb=%b, want a=%h b=%h ca/cb=%b",
                 i, obs.a, obs.b, obs.ca, obs.cb, exp.a, exp.b, want[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_midframe();
    exp_t obs, exp;
    bit ok;
    int errs;
    send_byte(8'h2B);
    for (int i = 0; i < 9; i++) send_byte(8'(8'hA0 + i));
    errs = n_err1 + n_err2 + n_err_bad;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready, err, err_code} !== 5'b01000 ||
        {out_op, out_a, out_b, out_cls_a, out_cls_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset: ctrl=%b op=%0d a=%h b=%h ca=%b cb=%b, want 01000 and zero data",
               {out_valid, in_ready, err, err_code}, out_op, out_a, out_b, out_cls_a, out_cls_b);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (n_err1 + n_err2 + n_err_bad !== errs) begin
      miscompares++;
      $display("[TB] FAIL midframe_no_err: got %0d err pulses, want 0", n_err1 + n_err2 + n_err_bad - errs);
    end
    send_frame(8'h2D, 64'h3FB999999999999A, 64'h7FEFFFFFFFFFFFFF);
    get_out(obs, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL midframe_fresh: got op=%0d a=%h b=%h ca=%b cb=%b, want op=%0d a=%h b=%h ca=%b cb=%b",
               obs.op, obs.a, obs.b, obs.ca, obs.cb, exp.op, exp.a, exp.b, exp.ca, exp.cb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t obs, exp;
    bit ok;
    logic [7:0] ops[4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_frame(ops[k], {$urandom, $urandom}, {$urandom, $urandom});
      get_out(obs, ok);
      exp = sb.pop_front();
      vectors++;
      if (!ok || obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d: got op=%0d a=%h b=%h ca=%b cb=%b, want op=%0d a=%h b=%h ca=%b cb=%b",
                 k, obs.op, obs.a, obs.b, obs.ca, obs.cb, exp.op, exp.a, exp.b, exp.ca, exp.cb);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (n_err_bad !== 0 || sb.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL final_state: bad err codes=%0d leftover=%0d, want 0 0", n_err_bad, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_opcode();
    test_backpressure();
    test_timeout();
    test_classify();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
